// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the completion-bus arbiter.
// A completion packet holds a destination preg tag and a ROB index.
package cdb_arbiter_pkg;
    localparam int CDB_NUM_FU = 3;
    localparam int ARCH_REGS  = 32;
    localparam int CDB_PREG_W = 7;
    localparam int CDB_ROB_W  = 5;

    typedef struct packed {
        logic [CDB_PREG_W-1:0] pd;
        logic [CDB_ROB_W-1:0]  rob_index;
    } cdb_pkt_t;
endpackage

// File: rtl/cdb_skid_fifo.sv
// Two-entry completion FIFO placed in front of each functional unit.
// A flush empties it and discards any push arriving in the same cycle.
module cdb_skid_fifo
    import cdb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  cdb_pkt_t   din,
    output cdb_pkt_t   head,
    output logic [1:0] count
);
    cdb_pkt_t mem [2];
    logic     rd_ptr;
    logic     wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one completion bus among NUM_FU functional units.
// It also owns the physical-register ready table read at dispatch.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU    = CDB_NUM_FU,
    parameter int PREG_W    = CDB_PREG_W,
    parameter int ROB_W     = CDB_ROB_W,
    parameter int ARCH_REGS = cdb_arbiter_pkg::ARCH_REGS
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  logic [NUM_FU-1:0][PREG_W-1:0]  fu_pd,
    input  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic                           alloc_en,
    input  logic [PREG_W-1:0]              alloc_pd,
    input  logic                           flush,
    output logic                           cdb_valid,
    output logic [PREG_W-1:0]              cdb_pd,
    output logic [ROB_W-1:0]               cdb_rob,
    output logic [0:(2**PREG_W)-1]         preg_ready
);
    localparam int GNT_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int NUM_PREG = 2**PREG_W;

    cdb_pkt_t          din   [NUM_FU];
    cdb_pkt_t          head  [NUM_FU];
    logic [1:0]        count [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] busy;

    logic [GNT_W-1:0]  rr_ptr;
    logic [GNT_W-1:0]  grant;
    logic              grant_valid;
    cdb_pkt_t          gnt_pkt;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        // Ready comes from the registered count only, so it never depends on this cycle's pop.
        assign fu_ready[i] = (count[i] != 2'd2);
        assign push[i]     = fu_valid[i] && fu_ready[i];
        assign busy[i]     = (count[i] != 2'd0);
        assign pop[i]      = grant_valid && (grant == GNT_W'(i));
        assign din[i]      = '{pd: fu_pd[i], rob_index: fu_rob[i]};

        cdb_skid_fifo u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[i]),
            .pop     (pop[i]),
            .flush   (flush),
            .din     (din[i]),
            .head    (head[i]),
            .count   (count[i])
        );
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant       = '0;
        gnt_pkt     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!grant_valid && busy[idx]) begin
                grant_valid = 1'b1;
                grant       = GNT_W'(idx);
                gnt_pkt     = head[idx];
            end
        end
    end

    assign cdb_valid = grant_valid;
    assign cdb_pd    = gnt_pkt.pd;
    assign cdb_rob   = gnt_pkt.rob_index;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant == GNT_W'(NUM_FU - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Later assignment wins: an alloc clear beats a same-cycle wakeup, preg 0 beats both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PREG; i++) preg_ready[i] <= (i < ARCH_REGS);
        end else begin
            if (cdb_valid) preg_ready[cdb_pd]   <= 1'b1;
            if (alloc_en)  preg_ready[alloc_pd] <= 1'b0;
            preg_ready[0] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order,
// backpressure, wakeup/alloc collision, flush and async reset.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic             clk;
    logic             reset_n;
    logic [2:0]       fu_valid;
    logic [2:0][6:0]  fu_pd;
    logic [2:0][4:0]  fu_rob;
    logic [2:0]       fu_ready;
    logic             alloc_en;
    logic [6:0]       alloc_pd;
    logic             flush;
    logic             cdb_valid;
    logic [6:0]       cdb_pd;
    logic [4:0]       cdb_rob;
    logic [0:127]     preg_ready;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fu_valid   (fu_valid),
        .fu_pd      (fu_pd),
        .fu_rob     (fu_rob),
        .fu_ready   (fu_ready),
        .alloc_en   (alloc_en),
        .alloc_pd   (alloc_pd),
        .flush      (flush),
        .cdb_valid  (cdb_valid),
        .cdb_pd     (cdb_pd),
        .cdb_rob    (cdb_rob),
        .preg_ready (preg_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backpressure scenario data
    logic [6:0] fu0_items [4] = '{7'd80, 7'd81, 7'd82, 7'd83};
    logic [6:0] fu1_items [3] = '{7'd90, 7'd91, 7'd92};
    logic [6:0] exp_seq   [7] = '{7'd80, 7'd90, 7'd81, 7'd91, 7'd82, 7'd92, 7'd83};
    logic [6:0] got_seq   [$];

    initial begin
        int i0, i1;
        logic acc0, acc1;

        reset_n  = 1'b0;
        fu_valid = '0;
        fu_pd    = '0;
        fu_rob   = '0;
        alloc_en = 1'b0;
        alloc_pd = '0;
        flush    = 1'b0;
        #23;
        reset_n  = 1'b1;
        step();

        // 1: reset state and single-request latency
        check_val("rst_rdy_lo", preg_ready[0:31], 32'hFFFF_FFFF);
        check_val("rst_rdy_hi", {31'd0, |preg_ready[32:127]}, 0);
        check_val("rst_fu_ready", fu_ready, 3'b111);
        check_val("rst_cdb_valid", cdb_valid, 0);
        check_val("rst_cdb_pd", cdb_pd, 0);
        check_val("rst_cdb_rob", cdb_rob, 0);

        alloc_en = 1'b1; alloc_pd = 7'd40;
        step();
        alloc_en = 1'b0;
        fu_valid = 3'b001; fu_pd[0] = 7'd40; fu_rob[0] = 5'd3;
        step();
        fu_valid = '0;
        check_val("lat_valid", cdb_valid, 1);
        check_val("lat_pd", cdb_pd, 40);
        check_val("lat_rob", cdb_rob, 3);
        check_val("lat_rdy40_early", preg_ready[40], 0);
        step();
        check_val("lat_rdy40", preg_ready[40], 1);
        check_val("lat_idle", cdb_valid, 0);

        // 2: contention; an idle flush returns rr_ptr to 0 first
        flush = 1'b1;
        step();
        flush = 1'b0;
        fu_valid = 3'b111;
        fu_pd[0] = 7'd50; fu_pd[1] = 7'd60; fu_pd[2] = 7'd70;
        fu_rob[0] = 5'd1; fu_rob[1] = 5'd2; fu_rob[2] = 5'd4;
        step();
        fu_valid = '0;
        check_val("rr_first", cdb_pd, 50);
        step();
        check_val("rr_second", cdb_pd, 60);
        check_val("rr_second_rob", cdb_rob, 2);
        step();
        check_val("rr_third", cdb_pd, 70);
        fu_valid = 3'b101; fu_pd[0] = 7'd51; fu_pd[2] = 7'd71;
        step();
        fu_valid = '0;
        check_val("rr_wrap_first", cdb_pd, 51);
        step();
        check_val("rr_wrap_second", cdb_pd, 71);
        check_val("rr_rdy70", preg_ready[70], 1);
        step();
        check_val("rr_idle", cdb_valid, 0);

        // 3: backpressure with held requests
        i0 = 0; i1 = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cdb_valid) got_seq.push_back(cdb_pd);
            if (cyc == 2) check_val("bp_fu1_full", fu_ready[1], 0);
            if (cyc == 3) check_val("bp_fu0_full", fu_ready[0], 0);
            fu_valid[0] = (i0 < 4);
            fu_valid[1] = (i1 < 3);
            fu_pd[0] = (i0 < 4) ? fu0_items[i0] : 7'd0;
            fu_pd[1] = (i1 < 3) ? fu1_items[i1] : 7'd0;
            acc0 = fu_valid[0] && fu_ready[0];
            acc1 = fu_valid[1] && fu_ready[1];
            step();
            if (acc0) i0++;
            if (acc1) i1++;
        end
        fu_valid = '0;
        check_val("bp_count", got_seq.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < got_seq.size()) check_val($sformatf("bp_seq%0d", k), got_seq[k], exp_seq[k]);
            else check_val($sformatf("bp_seq%0d", k), 32'hFFFF, exp_seq[k]);
        end

        // 4: wakeup/alloc collision and preg 0
        fu_valid = 3'b100; fu_pd[2] = 7'd45;
        step();
        fu_valid = '0;
        check_val("col_bcast", cdb_pd, 45);
        alloc_en = 1'b1; alloc_pd = 7'd45;
        step();
        check_val("col_rdy45", preg_ready[45], 0);
        alloc_pd = 7'd0;
        step();
        check_val("col_rdy0", preg_ready[0], 1);
        alloc_pd = 7'd5;
        step();
        alloc_en = 1'b0;
        check_val("col_rdy5", preg_ready[5], 0);

        // 5: flush with four entries buffered
        flush = 1'b1;
        step();
        flush = 1'b0;
        fu_valid = 3'b011; fu_pd[0] = 7'd100; fu_pd[1] = 7'd110;
        step();
        fu_valid = 3'b111; fu_pd[0] = 7'd101; fu_pd[1] = 7'd111; fu_pd[2] = 7'd120;
        step();
        fu_valid = '0;
        check_val("fl_inflight", cdb_pd, 110);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("fl_valid", cdb_valid, 0);
        check_val("fl_pd", cdb_pd, 0);
        check_val("fl_fu_ready", fu_ready, 3'b111);
        check_val("fl_rdy110", preg_ready[110], 1);
        check_val("fl_rdy100", preg_ready[100], 1);
        check_val("fl_rdy_drop", {29'd0, preg_ready[101], preg_ready[111], preg_ready[120]}, 0);
        step();
        check_val("fl_still_idle", cdb_valid, 0);

        // 6: async reset mid-stream
        fu_valid = 3'b111; fu_pd[0] = 7'd33; fu_pd[1] = 7'd34; fu_pd[2] = 7'd35;
        step();
        fu_pd[0] = 7'd36; fu_pd[1] = 7'd37; fu_pd[2] = 7'd38;
        step();
        fu_valid = '0;
        check_val("ar_busy", cdb_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("ar_valid", cdb_valid, 0);
        check_val("ar_pd", cdb_pd, 0);
        check_val("ar_fu_ready", fu_ready, 3'b111);
        check_val("ar_rdy33", preg_ready[33], 0);
        check_val("ar_rdy40", preg_ready[40], 0);
        check_val("ar_rdy5", preg_ready[5], 1);
        #12;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check_val($sformatf("ar_quiet%0d", c), cdb_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
